// File: rtl/sa_feeder.sv
// -----------------------------------------------------------------------------
// sa_feeder
//
// Operand feeder for an N x N systolic array of pe cells.
//
// Operation:
//   1. Collects K load beats of A columns and B rows into an operand buffer.
//   2. Pulses clr to the array for one cycle.
//   3. Streams the operands onto the west (x_o) and north (y_o) array edges
//      with the diagonal skew that the array needs.
//   4. Pulses done once the bottom-right pe has taken its last product.
//
// Ports:
//   clk       clock
//   rst_n     asynchronous active-low reset
//   in_valid  load beat valid
//   in_ready  feeder can accept a load beat (high only in LOAD)
//   a_col     A[i][k] for beat k, element i at [i*DW +: DW], signed
//   b_row     B[k][j] for beat k, element j at [j*DW +: DW], signed
//   x_o       west-edge operands, row i at [i*DW +: DW]
//   y_o       north-edge operands, column j at [j*DW +: DW]
//   clr       one-cycle synchronous clear to every pe
//   busy      high in CLEAR, STREAM and DONE
//   done      one-cycle pulse; pe results are final in this cycle
// -----------------------------------------------------------------------------
module sa_feeder #(
    parameter int DW = 8,
    parameter int N  = 4,
    parameter int K  = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N*DW-1:0] a_col,
    input  logic [N*DW-1:0] b_row,
    output logic [N*DW-1:0] x_o,
    output logic [N*DW-1:0] y_o,
    output logic            clr,
    output logic            busy,
    output logic            done
);

    // Length of the skewed stream: the last product reaches PE(N-1,N-1)
    // at stream index K-1 + (N-1) + (N-1).
    localparam int W  = K + 2*N - 2;
    localparam int BW = (K > 1) ? $clog2(K) : 1;
    localparam int SW = (W > 1) ? $clog2(W) : 1;

    typedef enum logic [1:0] {
        S_LOAD,
        S_CLEAR,
        S_STREAM,
        S_DONE
    } state_t;

    state_t                r_state;
    logic [BW-1:0]         r_beat;
    logic [SW-1:0]         r_stream;

    // Operand buffer: slot k holds beat k. Contents are don't-care after
    // reset, so it carries no reset.
    logic signed [DW-1:0]  r_a [K][N];
    logic signed [DW-1:0]  r_b [K][N];

    logic                  w_accept;

    assign w_accept = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (w_accept) begin
            for (int i = 0; i < N; i++) begin
                r_a[r_beat][i] <= a_col[i*DW +: DW];
                r_b[r_beat][i] <= b_row[i*DW +: DW];
            end
        end
    end

    // West edge for stream index s: row i carries A[i][s-i] when in range.
    function automatic logic [N*DW-1:0] skew_x(input int s);
        logic [N*DW-1:0] v;
        v = '0;
        for (int i = 0; i < N; i++) begin
            for (int k = 0; k < K; k++) begin
                if (s == i + k) begin
                    v[i*DW +: DW] = r_a[k][i];
                end
            end
        end
        return v;
    endfunction

    // North edge for stream index s: column j carries B[s-j][j] when in range.
    function automatic logic [N*DW-1:0] skew_y(input int s);
        logic [N*DW-1:0] v;
        v = '0;
        for (int j = 0; j < N; j++) begin
            for (int k = 0; k < K; k++) begin
                if (s == j + k) begin
                    v[j*DW +: DW] = r_b[k][j];
                end
            end
        end
        return v;
    endfunction

    // Control FSM. All outputs are registered; the edge that enters a
    // cycle loads the value that cycle must present, so x_o/y_o for stream
    // index s are computed one edge ahead (index 0 on the CLEAR->STREAM edge).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_LOAD;
            r_beat   <= '0;
            r_stream <= '0;
            in_ready <= 1'b1;
            x_o      <= '0;
            y_o      <= '0;
            clr      <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            clr  <= 1'b0;
            done <= 1'b0;
            case (r_state)
                S_LOAD: begin
                    if (w_accept) begin
                        if (r_beat == BW'(K-1)) begin
                            r_beat   <= '0;
                            r_state  <= S_CLEAR;
                            in_ready <= 1'b0;
                            clr      <= 1'b1;
                            busy     <= 1'b1;
                        end else begin
                            r_beat <= r_beat + BW'(1);
                        end
                    end
                end
                S_CLEAR: begin
                    // Last beat was written on the edge that entered CLEAR,
                    // so the buffer is complete here.
                    r_state  <= S_STREAM;
                    r_stream <= '0;
                    x_o      <= skew_x(0);
                    y_o      <= skew_y(0);
                end
                S_STREAM: begin
                    if (r_stream == SW'(W-1)) begin
                        // Zero operands keep the pe accumulators frozen.
                        r_state <= S_DONE;
                        x_o     <= '0;
                        y_o     <= '0;
                        done    <= 1'b1;
                    end else begin
                        r_stream <= r_stream + SW'(1);
                        x_o      <= skew_x(int'(r_stream) + 1);
                        y_o      <= skew_y(int'(r_stream) + 1);
                    end
                end
                S_DONE: begin
                    r_state  <= S_LOAD;
                    r_beat   <= '0;
                    in_ready <= 1'b1;
                    busy     <= 1'b0;
                end
                default: begin
                    r_state <= S_LOAD;
                end
            endcase
        end
    end

endmodule
